// File: rtl/logic_op_pkg.sv
// Shared types for the logic operation unit: opcode encoding and chain FSM states.
package logic_op_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHAIN = 1'b1
  } state_e;

endpackage

// File: rtl/logic_op_core.sv
// Purely combinational bitwise operator: y = op(x, b) over WIDTH bits.
module logic_op_core
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = x_i;
    case (op_e'(op_i))
      OP_AND:  y_o = x_i & b_i;
      OP_OR:   y_o = x_i | b_i;
      OP_NOT:  y_o = ~x_i;
      OP_NAND: y_o = ~(x_i & b_i);
      OP_NOR:  y_o = ~(x_i | b_i);
      OP_XOR:  y_o = x_i ^ b_i;
      OP_XNOR: y_o = ~(x_i ^ b_i);
      OP_PASS: y_o = x_i;
      default: y_o = x_i;
    endcase
  end

endmodule

// File: rtl/logic_op_unit.sv
// Registered bitwise logic unit with valid/ready handshake, chained reduction
// through an accumulator, zero/parity flags and a saturating result counter.
module logic_op_unit
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] ops_done,
  output logic             chaining
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               valid_q, valid_d;
  logic               zero_q, zero_d;
  logic               parity_q, parity_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic [WIDTH-1:0]   opX;
  logic [WIDTH-1:0]   coreY;

  // Chain beats also wait for the output slot so the source sees one uniform rule.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign opX      = (state_q == ST_CHAIN) ? acc_q : in_a;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .x_i  (opX),
    .b_i  (in_b),
    .op_i (in_op),
    .y_o  (coreY)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    y_d      = y_q;
    valid_d  = valid_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    cnt_d    = cnt_q;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      if (in_chain) begin
        acc_d   = coreY;
        state_d = ST_CHAIN;
      end else begin
        y_d      = coreY;
        zero_d   = (coreY == '0);
        parity_d = ^coreY;
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_y      = y_q;
  assign out_zero   = zero_q;
  assign out_parity = parity_q;
  assign ops_done   = cnt_q;
  assign chaining   = (state_q == ST_CHAIN);

endmodule

// File: tb/tb_logic_op_unit.sv
// Scoreboard bench for logic_op_unit: a behavioural model predicts each emitted
// result and a monitor checks it when the unit hands it over.
module tb_logic_op_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       in_chain;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_zero;
  logic       out_parity;
  logic [15:0] ops_done;
  logic       chaining;

  logic       satInReady, satOutValid, satZero, satParity, satChaining;
  logic [7:0] satY;
  logic [1:0] satOpsDone;

  logic_op_unit #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_zero(out_zero), .out_parity(out_parity), .ops_done(ops_done),
    .chaining(chaining)
  );

  // Narrow-counter twin sharing the same stimulus, to exercise saturation.
  logic_op_unit #(.WIDTH(8), .CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(satInReady),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
    .out_valid(satOutValid), .out_ready(out_ready), .out_y(satY),
    .out_zero(satZero), .out_parity(satParity), .ops_done(satOpsDone),
    .chaining(satChaining)
  );

  typedef struct {
    logic [7:0] y;
    int         count;
  } exp_t;

  exp_t sb[$];
  int   checkCount = 0;
  int   passCount  = 0;
  bit   randReady  = 0;

  logic       mValid;
  logic       mChain;
  logic [7:0] mAcc;
  int         mCount;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
  endtask

  function automatic logic [7:0] refOp(input logic [7:0] x, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return x & b;
      3'd1:    return x | b;
      3'd2:    return ~x;
      3'd3:    return ~(x & b);
      3'd4:    return ~(x | b);
      3'd5:    return x ^ b;
      3'd6:    return ~(x ^ b);
      default: return x;
    endcase
  endfunction

  // Reference model: tracks handshake, chain accumulator and result count.
  always @(negedge clk) begin
    logic [7:0] x;
    logic [7:0] r;
    logic       mReady;
    if (!rst_n) begin
      mValid = 1'b0;
      mChain = 1'b0;
      mAcc   = 8'h00;
      mCount = 0;
      sb.delete();
    end else begin
      checkOutput("out_valid", out_valid, mValid);
      checkOutput("in_ready", in_ready, !mValid || out_ready);
      checkOutput("chaining", chaining, mChain);
      checkOutput("sat_chaining", satChaining, mChain);
      mReady = !mValid || out_ready;
      if (mValid && out_ready) mValid = 1'b0;
      if (in_valid && mReady) begin
        x = mChain ? mAcc : in_a;
        r = refOp(x, in_b, in_op);
        if (in_chain) begin
          mAcc   = r;
          mChain = 1'b1;
        end else begin
          mCount++;
          sb.push_back('{y: r, count: mCount});
          mValid = 1'b1;
          mChain = 1'b0;
        end
      end
    end
  end

  // Monitor: each handed-over result is checked against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_result actual=%0h expected=none at %0t", out_y, $time);
      end else begin
        e = sb.pop_front();
        checkOutput("out_y", out_y, e.y);
        checkOutput("out_zero", out_zero, e.y == 8'h00);
        checkOutput("out_parity", out_parity, ^e.y);
        checkOutput("ops_done", ops_done, e.count);
        checkOutput("ops_done_sat", satOpsDone, (e.count > 3) ? 3 : e.count);
        checkOutput("sat_out_y", satY, e.y);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic chain);
    bit done;
    int waitCycles;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_chain = chain;
    done       = 0;
    waitCycles = 0;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      waitCycles++;
      @(posedge clk);
      #1;
      if (!done && waitCycles > 100) begin
        checkCount++;
        $display("[TB] FAIL accept_timeout actual=stalled expected=accept at %0t", $time);
        done = 1;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_y"}, out_y, 0);
    checkOutput({tag, "_out_zero"}, out_zero, 0);
    checkOutput({tag, "_out_parity"}, out_parity, 0);
    checkOutput({tag, "_ops_done"}, ops_done, 0);
    checkOutput({tag, "_chaining"}, chaining, 0);
    checkOutput({tag, "_sat_ops_done"}, satOpsDone, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_chain  = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    checkOutput("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    idleCycles(1);

    $display("[TB] opcode sweep");
    for (int op = 0; op < 8; op++) applyStimulus(8'hF0, 8'h3C, 3'(op), 1'b0);
    idleCycles(2);
    checkOutput("sweep_ops_done", ops_done, 8);
    checkOutput("sweep_sat_ops_done", satOpsDone, 3);

    $display("[TB] chained reduction");
    applyStimulus(8'hFF, 8'h0F, 3'd0, 1'b1);
    applyStimulus(8'h00, 8'h03, 3'd5, 1'b1);
    applyStimulus(8'h00, 8'hF0, 3'd1, 1'b0);
    idleCycles(2);
    checkOutput("chain_result", out_y, 8'hFC);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(8'h5A, 8'h0F, 3'd5, 1'b0);
    in_a  = 8'hC3;
    in_b  = 8'hFF;
    in_op = 3'd7;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_y", out_y, 8'h55);
      in_a  = 8'($urandom);
      in_op = 3'($urandom);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_a  = 8'hC3;
    in_op = 3'd7;
    @(negedge clk);
    checkOutput("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    idleCycles(1);
    checkOutput("bp_next_result", out_y, 8'hC3);

    $display("[TB] flags");
    applyStimulus(8'hAA, 8'hAA, 3'd5, 1'b0);
    applyStimulus(8'h01, 8'h00, 3'd1, 1'b0);
    idleCycles(2);

    $display("[TB] randomized traffic");
    randReady = 1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 3'($urandom),
                    (i == 299) ? 1'b0 : ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 4) == 0) idleCycles(1);
    end
    in_valid  = 1'b0;
    randReady = 0;
    out_ready = 1'b1;
    idleCycles(4);

    $display("[TB] reset mid-chain");
    applyStimulus(8'hFF, 8'h0F, 3'd0, 1'b1);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checkResetValues("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'h55, 8'hFF, 3'd0, 1'b0);
    idleCycles(2);
    checkOutput("post_reset_result", out_y, 8'h55);
    checkOutput("post_reset_ops_done", ops_done, 1);

    checkOutput("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
